counter_sweep_ctrl: RTL and testbench

Sequencer for the 4-bit synchronous up/down counter.
- Drives the counter's en/sel/trigger inputs and observes its count.
- Walks the count from its current value to a programmed low limit, then performs N triangular sweeps lo→hi→lo, one step per prescaled tick.
- Sits between a control/config source (start/limits) and the counter instance; reports busy/done/err.

---
 rtl/counter_sweep_ctrl_pkg.sv | 15 +
 rtl/counter_sweep_ctrl_if.sv | 25 ++
 rtl/counter_sweep_ctrl_tick_prescaler.sv | 25 ++
 rtl/counter_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package counter_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_UP,
    ST_DOWN,
    ST_DONE
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the config source (master) and the sequencer (slave).
interface counter_sweep_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 8
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   lo_limit;
  logic [WIDTH-1:0]   hi_limit;
  logic [SWEEP_W-1:0] n_sweeps;
  logic               busy;
  logic               done;
  logic               err;
  logic [SWEEP_W-1:0] sweeps_left;

  modport master (
    output start, abort, lo_limit, hi_limit, n_sweeps,
    input  busy, done, err, sweeps_left
  );

  modport slave (
    input  start, abort, lo_limit, hi_limit, n_sweeps,
    output busy, done, err, sweeps_left
  );
endinterface

// File: rtl/counter_sweep_ctrl_tick_prescaler.sv
// Step-tick generator: one tick every TICK_DIV cycles while run is high.
module counter_sweep_ctrl_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tick_cnt <= '0;
    end else if (run) begin
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign tick = run && (tick_cnt == LAST);
endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequencer that seeks an up/down counter to lo, then runs N lo->hi->lo sweeps.
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 4,
  parameter int SWEEP_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_sweep_ctrl_if.slave  cfg,
  input  logic [WIDTH-1:0]     ctr_count,
  output logic                 ctr_en,
  output logic                 ctr_sel,
  output logic                 ctr_trigger
);
  state_t             state;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [SWEEP_W-1:0] n_q;
  logic [SWEEP_W-1:0] sweeps_left_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               cfg_bad;
  logic               accept;
  logic               tick;

  always_comb begin
    cfg_bad = (cfg.lo_limit >= cfg.hi_limit) || (cfg.n_sweeps == '0);
    accept  = (state == ST_IDLE) && cfg.start && !cfg_bad;
  end

  counter_sweep_ctrl_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .run   (busy_q),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      n_q           <= '0;
      sweeps_left_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ctr_en        <= 1'b0;
      ctr_sel       <= DIR_UP;
      ctr_trigger   <= 1'b0;
    end else begin
      ctr_trigger <= 1'b0;
      done_q      <= 1'b0;
      if (state != ST_IDLE && cfg.abort) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
        ctr_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cfg.start) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                lo_q          <= cfg.lo_limit;
                hi_q          <= cfg.hi_limit;
                n_q           <= cfg.n_sweeps;
                sweeps_left_q <= cfg.n_sweeps;
                err_q         <= 1'b0;
                busy_q        <= 1'b1;
                ctr_en        <= 1'b1;
                state         <= ST_SEEK;
              end
            end
          end
          ST_SEEK: begin
            if (tick) begin
              if (ctr_count == lo_q) begin
                state <= ST_UP;
              end else begin
                ctr_trigger <= 1'b1;
                ctr_sel     <= (ctr_count > lo_q) ? DIR_DOWN : DIR_UP;
              end
            end
          end
          ST_UP: begin
            if (tick) begin
              if (ctr_count == hi_q) begin
                state <= ST_DOWN;
              end else begin
                ctr_trigger <= 1'b1;
                ctr_sel     <= DIR_UP;
              end
            end
          end
          ST_DOWN: begin
            if (tick) begin
              if (ctr_count == lo_q) begin
                sweeps_left_q <= sweeps_left_q - 1'b1;
                // Last sweep: leave busy now so done and !busy coincide in ST_DONE.
                if (sweeps_left_q == SWEEP_W'(1)) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  ctr_en <= 1'b0;
                  done_q <= 1'b1;
                end else begin
                  state <= ST_UP;
                end
              end else begin
                ctr_trigger <= 1'b1;
                ctr_sel     <= DIR_DOWN;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cfg.busy        = busy_q;
  assign cfg.done        = done_q;
  assign cfg.err         = err_q;
  assign cfg.sweeps_left = sweeps_left_q;
endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench: sequencer driving a behavioural 4-bit up/down counter.
module tb_counter_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctr_en, ctr_sel, ctr_trigger;
  logic [3:0] cnt;
  logic       ld = 1'b0;
  logic [3:0] ld_val = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         dn;
    logic       sel;
    logic [3:0] cnt;
    logic [7:0] sl;
  } ev_t;

  ev_t q[$];
  ev_t e;

  counter_sweep_ctrl_if #(.WIDTH(4), .SWEEP_W(8)) bus ();

  counter_sweep_ctrl #(
    .WIDTH    (4),
    .TICK_DIV (4),
    .SWEEP_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (bus.slave),
    .ctr_count   (cnt),
    .ctr_en      (ctr_en),
    .ctr_sel     (ctr_sel),
    .ctr_trigger (ctr_trigger)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (ld)                  cnt <= ld_val;
    else if (ctr_en && ctr_trigger) cnt <= ctr_sel ? cnt - 4'd1 : cnt + 4'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (ctr_trigger || bus.done)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: trig=%0d done=%0d count=%0d expected none (t=%0t)",
                 ctr_trigger, bus.done, cnt, $time);
      end else begin
        e = q.pop_front();
        check("event_is_done", int'(bus.done), int'(e.dn));
        if (!e.dn) check("trig_sel", int'(ctr_sel), int'(e.sel));
        check("event_count", int'(cnt), int'(e.cnt));
        check("event_sweeps_left", int'(bus.sweeps_left), int'(e.sl));
      end
    end
  end

  task automatic exp_trig(input logic s, input int c, input int sl);
    ev_t t;
    t.dn = 1'b0; t.sel = s; t.cnt = 4'(c); t.sl = 8'(sl);
    q.push_back(t);
  endtask

  task automatic exp_done(input int c);
    ev_t t;
    t.dn = 1'b1; t.sel = 1'b0; t.cnt = 4'(c); t.sl = 8'd0;
    q.push_back(t);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a one-cycle start; returns on the negedge after the accepting edge.
  task automatic pulse_start(input int lo, input int hi, input int n);
    bus.lo_limit = 4'(lo);
    bus.hi_limit = 4'(hi);
    bus.n_sweeps = 8'(n);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic load_count(input int v);
    ld = 1'b1;
    ld_val = 4'(v);
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic wait_empty(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (q.size() != 0 && k < budget);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_timeout: got %0d pending events expected 0", q.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_err"}, int'(bus.err), 0);
    check({tag, "_ctr_en"}, int'(ctr_en), 0);
    check({tag, "_ctr_sel"}, int'(ctr_sel), 0);
    check({tag, "_ctr_trigger"}, int'(ctr_trigger), 0);
    check({tag, "_sweeps_left"}, int'(bus.sweeps_left), 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.lo_limit = '0;
    bus.hi_limit = '0;
    bus.n_sweeps = '0;

    // Reset and idle
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    cyc(50);

    // Counter 0, lo=2 hi=5 n=1
    for (int c = 0; c < 5; c++) exp_trig(1'b0, c, 1);
    for (int c = 5; c > 2; c--) exp_trig(1'b1, c, 1);
    exp_done(2);
    pulse_start(2, 5, 1);
    check("run1_busy", int'(bus.busy), 1);
    check("run1_ctr_en", int'(ctr_en), 1);
    check("run1_sweeps_left", int'(bus.sweeps_left), 1);
    wait_done(n);
    check("run1_done_cycle", n, 45);
    check("run1_done_busy", int'(bus.busy), 0);
    check("run1_done_sel_held", int'(ctr_sel), 1);
    wait_empty(5);
    @(negedge clk);
    check("run1_done_one_cycle", int'(bus.done), 0);

    // Counter 9, lo=3 hi=7 n=2
    load_count(9);
    for (int c = 9; c > 3; c--) exp_trig(1'b1, c, 2);
    for (int s = 2; s >= 1; s--) begin
      for (int c = 3; c < 7; c++) exp_trig(1'b0, c, s);
      for (int c = 7; c > 3; c--) exp_trig(1'b1, c, s);
    end
    exp_done(3);
    pulse_start(3, 7, 2);
    wait_done(n);
    wait_empty(5);

    // Config error, then valid start clears err
    pulse_start(5, 5, 3);
    check("cfgerr_err", int'(bus.err), 1);
    check("cfgerr_busy", int'(bus.busy), 0);
    check("cfgerr_sweeps_left", int'(bus.sweeps_left), 0);
    cyc(20);
    check("cfgerr_err_held", int'(bus.err), 1);
    exp_trig(1'b1, 3, 1);
    exp_trig(1'b1, 2, 1);
    exp_trig(1'b0, 1, 1);
    exp_trig(1'b1, 2, 1);
    exp_done(1);
    pulse_start(1, 2, 1);
    check("valid_err_cleared", int'(bus.err), 0);
    check("valid_busy", int'(bus.busy), 1);
    wait_done(n);
    wait_empty(5);

    // Abort in second sweep's UP phase
    exp_trig(1'b0, 1, 2);
    exp_trig(1'b0, 2, 2);
    for (int c = 3; c < 7; c++) exp_trig(1'b0, c, 2);
    for (int c = 7; c > 3; c--) exp_trig(1'b1, c, 2);
    exp_trig(1'b0, 3, 1);
    exp_trig(1'b0, 4, 1);
    pulse_start(3, 7, 2);
    wait_empty(300);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_ctr_en", int'(ctr_en), 0);
    check("abort_sweeps_left", int'(bus.sweeps_left), 1);
    check("abort_trigger", int'(ctr_trigger), 0);
    cyc(30);
    check("abort_sweeps_left_frozen", int'(bus.sweeps_left), 1);

    // Start while busy is ignored; rst mid-DOWN
    exp_trig(1'b1, 5, 1);
    pulse_start(2, 4, 1);
    wait_empty(50);
    pulse_start(0, 9, 5);
    check("busy_start_sweeps_left", int'(bus.sweeps_left), 1);
    check("busy_start_err", int'(bus.err), 0);
    exp_trig(1'b1, 4, 1);
    exp_trig(1'b1, 3, 1);
    exp_trig(1'b0, 2, 1);
    exp_trig(1'b0, 3, 1);
    exp_trig(1'b1, 4, 1);
    wait_empty(200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");
    cyc(20);
    check("final_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
